if_mem_port: RTL and testbench

//  Instruction-fetch responder inside the memory controller; answers the fetcher's if_to_mc_* requests.

---
 rtl/if_mem_port_pkg.sv | 15 +
 rtl/if_mem_port_byte_assembler.sv | 53 +++++
 rtl/if_mem_port.sv | 135 +++++++++++++
 tb/tb_if_mem_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_mem_port_pkg.sv
// Shared types and constants for the instruction-fetch memory port.
package if_mem_port_pkg;

  localparam logic [2:0] BYTES_PER_INST = 3'd4;
  localparam logic [1:0] LAST_BYTE      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_DONE,
    ST_HIT
  } ifp_state_t;

endpackage

// File: rtl/if_mem_port_byte_assembler.sv
// Byte-serial read engine: issues up to four byte addresses, tracks the one-cycle
// RAM latency and shifts bytes into a little-endian word.
module ifp_byte_assembler
  import if_mem_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        issue_ok,
  input  logic [7:0]  mem_din,
  output logic        issue,
  output logic [2:0]  issue_cnt,
  output logic        done,
  output logic [31:0] word
);

  logic       issued;
  logic [1:0] cap_cnt;
  logic       full;

  assign issue = issue_ok && (issue_cnt < BYTES_PER_INST);
  // full remembers a completed word while the parent is paused by rdy
  assign done  = full || (issued && (cap_cnt == LAST_BYTE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      issued    <= 1'b0;
      cap_cnt   <= '0;
      full      <= 1'b0;
      word      <= '0;
    end else if (clear) begin
      issue_cnt <= '0;
      issued    <= 1'b0;
      cap_cnt   <= '0;
      full      <= 1'b0;
    end else begin
      issued <= issue;
      if (issue) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (issued) begin
        // byte k lands in bits [8k+7:8k] after four shifts from the top
        word    <= {mem_din, word[31:8]};
        cap_cnt <= cap_cnt + 2'd1;
        if (cap_cnt == LAST_BYTE) begin
          full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/if_mem_port.sv
// Instruction-fetch responder: arbitrates for the byte RAM bus, reads PC..PC+3 and
// returns the assembled word. Optional one-entry reuse buffer under IFP_REUSE_EN.
module if_mem_port
  import if_mem_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  if_to_mc_ready,
  input  logic [ADDR_WIDTH-1:0] if_to_mc_PC,
  output logic                  mc_to_if_valid,
  output logic                  mc_to_if_ready,
  output logic [INST_WIDTH-1:0] mc_to_if_inst,
  output logic [ADDR_WIDTH-1:0] mc_to_if_addr,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic [7:0]            mem_din,
  output logic                  mem_wr,
  input  logic                  inv_in
);

  ifp_state_t            state;
  ifp_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic                  accept;
  logic                  accept_d;
  logic                  hit;
  logic                  asm_issue;
  logic [2:0]            asm_cnt;
  logic                  asm_done;
  logic [INST_WIDTH-1:0] asm_word;
  logic [INST_WIDTH-1:0] done_inst;

  ifp_byte_assembler u_asm (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .clear     (clr_in || (state != ST_READ)),
    .issue_ok  ((state == ST_READ) && rdy_in && !clr_in && bus_grant),
    .mem_din   (mem_din),
    .issue     (asm_issue),
    .issue_cnt (asm_cnt),
    .done      (asm_done),
    .word      (asm_word)
  );

`ifdef IFP_REUSE_EN
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [INST_WIDTH-1:0] buf_inst;
  logic                  from_buf;

  assign hit       = buf_valid && !inv_in && (if_to_mc_PC == buf_addr);
  assign done_inst = from_buf ? buf_inst : asm_word;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_inst  <= '0;
      from_buf  <= 1'b0;
    end else begin
      if (clr_in || inv_in) begin
        buf_valid <= 1'b0;
      end else if (state == ST_DONE) begin
        buf_valid <= 1'b1;
        buf_addr  <= base;
        buf_inst  <= done_inst;
      end
      if (clr_in || (state == ST_DONE)) begin
        from_buf <= 1'b0;
      end else if (accept && hit) begin
        from_buf <= 1'b1;
      end
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv_in;
  assign hit        = 1'b0;
  assign done_inst  = asm_word;
`endif

  // DONE always lasts exactly one cycle; every other state is frozen while rdy_in is low
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (clr_in) begin
      state_nxt = ST_IDLE;
    end else if (state == ST_DONE) begin
      state_nxt = ST_IDLE;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (if_to_mc_ready) begin
            accept    = 1'b1;
            state_nxt = hit ? ST_HIT : ST_REQ;
          end
        end
        ST_REQ:  if (bus_grant) state_nxt = ST_READ;
        ST_READ: if (asm_done)  state_nxt = ST_DONE;
        ST_HIT:  if (!accept_d) state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= ST_IDLE;
      base           <= '0;
      accept_d       <= 1'b0;
      mc_to_if_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      accept_d       <= accept;
      mc_to_if_valid <= accept_d && !clr_in;
      if (accept) begin
        base <= if_to_mc_PC;
      end
    end
  end

  assign bus_req        = (state == ST_REQ) || (state == ST_READ);
  assign mem_a          = asm_issue ? (base + ADDR_WIDTH'(asm_cnt)) : '0;
  assign mem_wr         = 1'b0;
  assign mc_to_if_ready = (state == ST_DONE);
  assign mc_to_if_inst  = (state == ST_DONE) ? done_inst : '0;
  assign mc_to_if_addr  = (state == ST_DONE) ? base : '0;

endmodule

// File: tb/tb_if_mem_port.sv
// Directed bench for if_mem_port with a registered byte RAM and a delay-programmable
// arbiter. Reuse-buffer steps are built only when IFP_REUSE_EN is defined.
module tb_if_mem_port;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clr_in = 1'b0;
  logic        if_to_mc_ready = 1'b0;
  logic [31:0] if_to_mc_PC = '0;
  logic        inv_in = 1'b0;
  logic        bus_grant;
  logic [7:0]  mem_din;
  logic        mc_to_if_valid, mc_to_if_ready, bus_req, mem_wr;
  logic [31:0] mc_to_if_inst, mc_to_if_addr, mem_a;

  int checks = 0;
  int errors = 0;
  int grant_delay = 0;
  int req_cnt = 0;

  if_mem_port dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clr_in         (clr_in),
    .if_to_mc_ready (if_to_mc_ready),
    .if_to_mc_PC    (if_to_mc_PC),
    .mc_to_if_valid (mc_to_if_valid),
    .mc_to_if_ready (mc_to_if_ready),
    .mc_to_if_inst  (mc_to_if_inst),
    .mc_to_if_addr  (mc_to_if_addr),
    .bus_req        (bus_req),
    .bus_grant      (bus_grant),
    .mem_a          (mem_a),
    .mem_din        (mem_din),
    .mem_wr         (mem_wr),
    .inv_in         (inv_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h00;
      32'h0000_1003: return 8'h00;
      32'h0000_3000: return 8'h11;
      32'h0000_3001: return 8'h22;
      32'h0000_3002: return 8'h33;
      32'h0000_3003: return 8'h44;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      32'h0000_0000: return 8'hCC;
      32'h0000_0001: return 8'hDD;
      default:       return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Arbiter grants once bus_req has been high for grant_delay cycles; RAM has one cycle of latency
  assign bus_grant = bus_req && (req_cnt >= grant_delay);

  always @(posedge clk_in) begin
    req_cnt <= bus_req ? req_cnt + 1 : 0;
    mem_din <= ram_byte(mem_a);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Moves into the next cycle and drives that cycle's inputs; checks follow mid-cycle
  task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic clr,
                               input logic rdy, input logic inv);
    @(posedge clk_in);
    #1;
    if_to_mc_ready = req;
    if_to_mc_PC    = pc;
    clr_in         = clr;
    rdy_in         = rdy;
    inv_in         = inv;
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  // Uncontended fetch: request sampled at edge N, valid and mem_a=base in cycle N+1, ready in N+6
  task automatic runFetch(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    applyStimulus(1'b1, pc, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput({tag, " req_N"}, 32'(bus_req), 32'd1);
    checkOutput({tag, " valid_N"}, 32'(mc_to_if_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idleCycle();
      checkOutput({tag, " mem_a"}, mem_a, pc + 32'(k));
      checkOutput({tag, " valid"}, 32'(mc_to_if_valid), (k == 0) ? 32'd1 : 32'd0);
    end
    idleCycle();
    checkOutput({tag, " mem_a_N5"}, mem_a, 32'h0);
    checkOutput({tag, " ready_N5"}, 32'(mc_to_if_ready), 32'd0);
    idleCycle();
    checkOutput({tag, " ready"}, 32'(mc_to_if_ready), 32'd1);
    checkOutput({tag, " inst"}, mc_to_if_inst, inst);
    checkOutput({tag, " addr"}, mc_to_if_addr, pc);
    checkOutput({tag, " req_done"}, 32'(bus_req), 32'd0);
    idleCycle();
    checkOutput({tag, " ready_end"}, 32'(mc_to_if_ready), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    #3;
    checkOutput("rst valid", 32'(mc_to_if_valid), 32'd0);
    checkOutput("rst ready", 32'(mc_to_if_ready), 32'd0);
    checkOutput("rst req", 32'(bus_req), 32'd0);
    checkOutput("rst mem_a", mem_a, 32'h0);
    checkOutput("rst inst", mc_to_if_inst, 32'h0);
    checkOutput("rst wr", 32'(mem_wr), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    idleCycle();
    checkOutput("idle req", 32'(bus_req), 32'd0);

    // T1 basic fetch
    runFetch("t1", 32'h0000_1000, 32'h0000_0513);

    // T2 grant held off five cycles; inv keeps a reuse build on the RAM path
    grant_delay = 5;
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("t2 req_wait", 32'(bus_req), 32'd1);
      checkOutput("t2 mem_a_wait", mem_a, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      idleCycle();
      checkOutput("t2 mem_a", mem_a, 32'h0000_1000 + 32'(k));
    end
    idleCycle();
    checkOutput("t2 ready_early", 32'(mc_to_if_ready), 32'd0);
    idleCycle();
    checkOutput("t2 ready", 32'(mc_to_if_ready), 32'd1);
    checkOutput("t2 inst", mc_to_if_inst, 32'h0000_0513);
    checkOutput("t2 addr", mc_to_if_addr, 32'h0000_1000);
    grant_delay = 0;
    idleCycle();

    // T3 flush while issuing byte 2, with a same-edge request that must be dropped
    applyStimulus(1'b1, 32'h0000_1800, 1'b0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("t3 mem_a0", mem_a, 32'h0000_1800);
    idleCycle();
    checkOutput("t3 mem_a1", mem_a, 32'h0000_1801);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
    idleCycle();
    checkOutput("t3 req_after_clr", 32'(bus_req), 32'd0);
    checkOutput("t3 mem_a_after_clr", mem_a, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput("t3 no_ready", 32'(mc_to_if_ready), 32'd0);
      checkOutput("t3 no_req", 32'(bus_req), 32'd0);
    end
    runFetch("t3b", 32'h0000_2000, 32'hA6A7_A4A5);

    // T4 pause after byte 1 is issued
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("t4 mem_a0", mem_a, 32'h0000_3000);
    idleCycle();
    checkOutput("t4 mem_a1", mem_a, 32'h0000_3001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("t4 mem_a_paused", mem_a, 32'h0);
      checkOutput("t4 req_paused", 32'(bus_req), 32'd1);
    end
    idleCycle();
    checkOutput("t4 mem_a2", mem_a, 32'h0000_3002);
    idleCycle();
    checkOutput("t4 mem_a3", mem_a, 32'h0000_3003);
    idleCycle();
    checkOutput("t4 ready_early", 32'(mc_to_if_ready), 32'd0);
    idleCycle();
    checkOutput("t4 ready", 32'(mc_to_if_ready), 32'd1);
    checkOutput("t4 inst", mc_to_if_inst, 32'h4433_2211);
    checkOutput("t4 addr", mc_to_if_addr, 32'h0000_3000);
    idleCycle();

    // T5 address wrap
    runFetch("t5", 32'hFFFF_FFFE, 32'hDDCC_BBAA);

    // Reset pulled mid-read
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0);
    idleCycle();
    idleCycle();
    idleCycle();
    rst_in = 1'b0;
    #1;
    checkOutput("rst_mid req", 32'(bus_req), 32'd0);
    checkOutput("rst_mid mem_a", mem_a, 32'h0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("rst_mid no_ready", 32'(mc_to_if_ready), 32'd0);
    end

`ifdef IFP_REUSE_EN
    // T6 reuse hit, then invalidate and refetch through RAM
    runFetch("t6a", 32'h0000_1000, 32'h0000_0513);
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("t6 hit_req_N", 32'(bus_req), 32'd0);
    idleCycle();
    checkOutput("t6 hit_valid", 32'(mc_to_if_valid), 32'd1);
    checkOutput("t6 hit_req_N1", 32'(bus_req), 32'd0);
    checkOutput("t6 hit_ready_N1", 32'(mc_to_if_ready), 32'd0);
    idleCycle();
    checkOutput("t6 hit_ready", 32'(mc_to_if_ready), 32'd1);
    checkOutput("t6 hit_inst", mc_to_if_inst, 32'h0000_0513);
    checkOutput("t6 hit_addr", mc_to_if_addr, 32'h0000_1000);
    checkOutput("t6 hit_mem_a", mem_a, 32'h0);
    idleCycle();
    checkOutput("t6 hit_ready_end", 32'(mc_to_if_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    runFetch("t6b", 32'h0000_1000, 32'h0000_0513);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
